// File: rtl/sensor_pio_pkg.sv
// Shared constants for the sensor input capture PIO: register addresses,
// edge-type encodings and the per-bit edge qualifier.
package sensor_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic edge_hit(input logic prev, input logic nxt, input int etype);
        case (etype)
            EDGE_FALL: return prev & ~nxt;
            EDGE_ANY:  return prev ^ nxt;
            default:   return ~prev & nxt;
        endcase
    endfunction

endpackage

// File: rtl/sensor_in_debounce.sv
// One sensor line: synchronizer chain, optional debounce counter and the stable flop.
// Debounce is compiled in when SENSOR_IN_DEBOUNCE_EN is defined.
module sensor_in_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_stable,
    output logic o_stable_nxt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic                   w_sync_out;
    logic                   w_stable_nxt;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef SENSOR_IN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A new level is accepted on the edge after the counter has seen it
    // differ for DEBOUNCE_CYCLES edges, giving SYNC_STAGES+1+DEBOUNCE_CYCLES latency.
    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = '0;
        if (w_sync_out != r_stable) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) w_stable_nxt = w_sync_out;
            else                                  w_cnt_nxt    = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_cnt_nxt;
    end
`else
    assign w_stable_nxt = w_sync_out;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_stable <= 1'b0;
        else       r_stable <= w_stable_nxt;
    end

    assign o_stable     = r_stable;
    assign o_stable_nxt = w_stable_nxt;

endmodule

// File: rtl/sensor_in_capture_pio.sv
// Avalon-MM sensor input PIO: synchronized/debounced DATA, IRQMASK, W1C EDGECAPTURE, level irq.
// Define SENSOR_IN_DEBOUNCE_EN to enable the per-line debounce counters.
module sensor_in_capture_pio
    import sensor_pio_pkg::*;
#(
    parameter int WIDTH           = 9,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [31-WIDTH:0] w_unused_wdata;
    logic             w_wr;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        sensor_in_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_line (
            .clk          (clk),
            .reset        (reset),
            .i_in         (in_port[i]),
            .o_stable     (w_stable[i]),
            .o_stable_nxt (w_stable_nxt[i])
        );
        assign w_edge[i] = edge_hit(w_stable[i], w_stable_nxt[i], EDGE_TYPE);
    end

    // Avalon write: one transfer per cycle with chipselect high and write_n low; no wait states.
    assign w_wr           = chipselect && !write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = writedata[31:WIDTH];
    assign w_clr          = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

    // Capture is applied after the clear so a coincident edge keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && address == ADDR_IRQMASK) r_irqmask <= w_wdata;
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = w_stable;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
            default:      readdata            = '0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule
